// File: rtl/cnn_pkg.sv
// Shared CNN helpers: per-channel unsigned max over packed channel vectors.
// Vectors are zero-extended to VEC_MAX_W; callers pass their channel width and count.
package cnn_pkg;

  localparam int unsigned VEC_MAX_W = 1024;
  localparam int unsigned CH_MAX_W  = 32;

  typedef logic [VEC_MAX_W-1:0] vec_t;

  typedef enum logic [0:0] {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_t;

  // Channel k occupies bits [k*w +: w]; w must not exceed CH_MAX_W.
  function automatic vec_t vec_max(input vec_t a, input vec_t b,
                                   input int unsigned w, input int unsigned c);
    vec_t                r;
    logic [CH_MAX_W-1:0] mask;
    logic [CH_MAX_W-1:0] ak;
    logic [CH_MAX_W-1:0] bk;
    r    = '0;
    mask = CH_MAX_W'((33'd1 << w) - 33'd1);
    for (int unsigned k = 0; k < c; k++) begin
      ak = CH_MAX_W'(a >> (k * w)) & mask;
      bk = CH_MAX_W'(b >> (k * w)) & mask;
      r  = r | (VEC_MAX_W'((ak > bk) ? ak : bk) << (k * w));
    end
    return r;
  endfunction

endpackage

// File: rtl/pool_row_acc_mp1.sv
// Row accumulator for the pooling stage: one entry per input column,
// combinational read, synchronous write, cleared on reset.
module pool_row_acc_mp1
  import cnn_pkg::*;
#(
  parameter int unsigned pDEPTH = 112,
  parameter int unsigned pVEC_W = 192,
  parameter int unsigned pADDR_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [pADDR_W-1:0] i_rd_addr,
  output logic [pVEC_W-1:0]  o_rd_data,
  input  logic               i_wr_en,
  input  logic [pADDR_W-1:0] i_wr_addr,
  input  logic [pVEC_W-1:0]  i_wr_data
);

  logic [pVEC_W-1:0] r_mem [pDEPTH];

  assign o_rd_data = r_mem[i_rd_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < pDEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/maxpool_conv1.sv
// Streaming 3x3 / stride-2 / pad-1 max-pool. A row accumulator carries the
// vertical max between row pairs; register h carries the horizontal max.
module maxpool_conv1
  import cnn_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH   = 8,
  parameter int unsigned pCHANNEL      = 24,
  parameter int unsigned pINPUT_WIDTH  = 112,
  parameter int unsigned pINPUT_HEIGHT = 112
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            data_valid,
  input  logic [pDATA_WIDTH*pCHANNEL-1:0] data_in,
  output logic [pDATA_WIDTH*pCHANNEL-1:0] data_out,
  output logic                            valid,
  output logic                            done
);

  localparam int unsigned VW = pDATA_WIDTH * pCHANNEL;
  localparam int unsigned CW = (pINPUT_WIDTH  > 1) ? $clog2(pINPUT_WIDTH)  : 1;
  localparam int unsigned RW = (pINPUT_HEIGHT > 1) ? $clog2(pINPUT_HEIGHT) : 1;

  function automatic logic [VW-1:0] pmax(input logic [VW-1:0] a, input logic [VW-1:0] b);
    return VW'(vec_max(VEC_MAX_W'(a), VEC_MAX_W'(b), pDATA_WIDTH, pCHANNEL));
  endfunction

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [VW-1:0] r_h;

  logic          w_accept;
  logic          w_last_col;
  logic          w_last_row;
  phase_t        w_row_ph;
  phase_t        w_col_ph;
  logic [VW-1:0] w_acc_rd;
  logic [VW-1:0] w_acc_eff;
  logic [VW-1:0] w_v;
  logic [VW-1:0] w_h_eff;
  logic [VW-1:0] w_hmax;
  logic [VW-1:0] w_wr_data;

  assign w_accept   = en && data_valid;
  assign w_last_col = (r_col == CW'(pINPUT_WIDTH - 1));
  assign w_last_row = (r_row == RW'(pINPUT_HEIGHT - 1));
  assign w_row_ph   = phase_t'(r_row[0]);
  assign w_col_ph   = phase_t'(r_col[0]);

  // Row 0 ignores whatever the previous frame left in the accumulator (top padding).
  assign w_acc_eff  = (r_row == '0) ? '0 : w_acc_rd;
  assign w_v        = pmax(w_acc_eff, data_in);
  // Odd rows seed the next window with the raw pixel; rows 2k+1 are shared.
  assign w_wr_data  = (w_row_ph == PH_ODD) ? data_in : w_v;
  assign w_h_eff    = (r_col == '0) ? '0 : r_h;
  assign w_hmax     = pmax(w_h_eff, w_v);

  pool_row_acc_mp1 #(
    .pDEPTH (pINPUT_WIDTH),
    .pVEC_W (VW),
    .pADDR_W(CW)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .i_rd_addr(r_col),
    .o_rd_data(w_acc_rd),
    .i_wr_en  (w_accept),
    .i_wr_addr(r_col),
    .i_wr_data(w_wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_h      <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      done     <= 1'b0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_row_ph == PH_ODD) begin
          if (w_col_ph == PH_EVEN) begin
            r_h <= w_hmax;
          end else begin
            r_h      <= w_v;
            data_out <= w_hmax;
            valid    <= 1'b1;
            done     <= w_last_row && w_last_col;
          end
        end
      end
    end
  end

endmodule
